aggregation_fifo: RTL and testbench



---
 rtl/aggregation_pkg.sv | 13 +
 rtl/aggregation_fifo_memory.sv | 31 +++
 rtl/aggregation_fifo.sv | 103 ++++++++++
 tb/tb_aggregation_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/aggregation_pkg.sv
// Shared definitions for the aggregation FIFO slice: pointer sizing and lane element type.
package aggregation_pkg;

  localparam int unsigned LANE_WIDTH = 8;

  typedef logic signed [LANE_WIDTH-1:0] lane_t;

  // Pointer width carries one extra wrap bit above the storage address.
  function automatic int ptr_w(input int height);
    return $clog2(height) + 1;
  endfunction

endpackage

// File: rtl/aggregation_fifo_memory.sv
// Storage array for the aggregation FIFO: one synchronous write port, zero-cycle read port.
module fifo_memory #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WIDTH-1:0]  read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  always_comb begin
    read_data = '0;
    if (read_en) begin
      read_data = mem[read_addr];
    end
  end

endmodule

// File: rtl/aggregation_fifo.sv
// Valid/ready first-word-fall-through FIFO controller with occupancy, almost-full and high-water tracking.
module aggregation_fifo
  import aggregation_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PARALLELISM  = 1,
  parameter int HEIGHT       = 128,
  parameter int AFULL_THRESH = HEIGHT - 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [PARALLELISM*WIDTH-1:0]  in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [PARALLELISM*WIDTH-1:0]  out_data,
  output logic [ptr_w(HEIGHT)-1:0]             count,
  output logic                                 almost_full,
  output logic [ptr_w(HEIGHT)-1:0]             high_water
);

  localparam int DW = PARALLELISM * WIDTH;
  localparam int PW = ptr_w(HEIGHT);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] count_q, count_nxt, hw_q;
  logic          afull_q;
  logic          empty, full, push, pop;
  logic [DW-1:0] rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fifo_memory #(
    .WIDTH  (DW),
    .DEPTH  (HEIGHT),
    .ADDR_W (AW)
  ) u_mem (
    .clk        (clk),
    .write_en   (push),
    .write_addr (wr_ptr[AW-1:0]),
    .write_data (in_data),
    .read_en    (1'b1),
    .read_addr  (rd_ptr[AW-1:0]),
    .read_data  (rd_data)
  );

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = rd_data;
    end
  end

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count_q + PW'(1);
    end else if (pop && !push) begin
      count_nxt = count_q - PW'(1);
    end
  end

  // A push during flush still writes storage, but the pointer reset discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hw_q    <= '0;
      afull_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count_q <= count_nxt;
      afull_q <= (count_nxt >= AFULL_LVL);
      if (count_nxt > hw_q) begin
        hw_q <= count_nxt;
      end
    end
  end

  assign count       = count_q;
  assign almost_full = afull_q;
  assign high_water  = hw_q;

endmodule

// File: tb/tb_aggregation_fifo.sv
// Directed self-checking bench for aggregation_fifo (HEIGHT=8, AFULL_THRESH=4).
module tb_aggregation_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [7:0] in_data, out_data;
  logic [3:0] count, high_water;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  aggregation_fifo #(
    .WIDTH        (8),
    .PARALLELISM  (1),
    .HEIGHT       (8),
    .AFULL_THRESH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .high_water  (high_water)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " in_ready"},    32'(in_ready),    32'd1);
    chk({tag, " out_valid"},   32'(out_valid),   32'd0);
    chk({tag, " count"},       32'(count),       32'd0);
    chk({tag, " out_data"},    32'(out_data),    32'd0);
    chk({tag, " almost_full"}, 32'(almost_full), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset state
    check_idle("t1");
    chk("t1 high_water", 32'(high_water), 32'd0);

    // 2: three pushes, then three pops in order
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("t2 out_valid_after_first", 32'(out_valid), 32'd1);
    chk("t2 head_first",            32'(out_data),  32'h11);
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    chk("t2 count3", 32'(count),      32'd3);
    chk("t2 hw3",    32'(high_water), 32'd3);
    chk("t2 afull",  32'(almost_full), 32'd0);
    out_ready = 1'b1;
    chk("t2 pop0", 32'(out_data), 32'h11); tick();
    chk("t2 pop1", 32'(out_data), 32'h22); tick();
    chk("t2 pop2", 32'(out_data), 32'h33); tick();
    out_ready = 1'b0;
    chk("t2 out_valid_fall", 32'(out_valid), 32'd0);
    chk("t2 count0",         32'(count),     32'd0);

    // 3: fill to full, blocked push, one pop frees a slot
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
      tick();
      chk("t3 count", 32'(count),       32'(i + 1));
      chk("t3 afull", 32'(almost_full), (i + 1 >= 4) ? 32'd1 : 32'd0);
    end
    chk("t3 in_ready_full", 32'(in_ready), 32'd0);
    in_data = 8'hEE;
    tick();
    chk("t3 count_blocked", 32'(count),      32'd8);
    chk("t3 hw8",           32'(high_water), 32'd8);
    out_ready = 1'b1;
    chk("t3 head", 32'(out_data), 32'h80);
    tick();
    in_valid = 1'b0;
    chk("t3 in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t3 count7",             32'(count),    32'd7);
    for (int i = 1; i < 8; i++) begin
      chk("t3 drain", 32'(out_data), 32'(8'h80 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("t3 empty", 32'(out_valid), 32'd0);
    chk("t3 afull_low", 32'(almost_full), 32'd0);

    // 4: occupancy 5, streaming push+pop across pointer wrap
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      tick();
    end
    chk("t4 count5", 32'(count), 32'd5);
    out_ready = 1'b1;
    for (int k = 5; k < 25; k++) begin
      in_data = 8'(8'h40 + k);
      chk("t4 stream_data",  32'(out_data), 32'(8'h40 + k - 5));
      tick();
      chk("t4 stream_count", 32'(count),    32'd5);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4 head_after", 32'(out_data), 32'h54);

    // 5: fresh reset so high_water reaches exactly 6, then flush with both handshakes offered
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h60 + i);
      tick();
    end
    chk("t5 count6", 32'(count),      32'd6);
    chk("t5 hw6",    32'(high_water), 32'd6);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_idle("t5 flushed");
    chk("t5 hw_kept", 32'(high_water), 32'd6);
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    chk("t5 no_stale_push", 32'(out_data), 32'h99);
    chk("t5 count1",        32'(count),    32'd1);

    // 6: asynchronous reset between edges mid-burst
    in_valid = 1'b1; in_data = 8'hA1; tick();
    in_data = 8'hA2;
    #2;
    rst = 1'b1;
    #1;
    check_idle("t6 async");
    chk("t6 hw", 32'(high_water), 32'd0);
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    tick();
    check_idle("t6 released");
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("t6 out_valid", 32'(out_valid), 32'd1);
    chk("t6 out_data",  32'(out_data),  32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
